// File: rtl/input_prefetch_fifo_pkg.sv
// Shared defaults and handshake state encodings for the input prefetch buffer.
package input_prefetch_fifo_pkg;

    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        U_IDLE     = 2'd0,
        U_REQ      = 2'd1,
        U_WAIT_LOW = 2'd2
    } up_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dn_state_e;

endpackage

// File: rtl/input_prefetch_fifo_if.sv
// 4-phase req/ack word channel; the requester is master, the data source is slave.
interface input_prefetch_fifo_if #(
    parameter int unsigned DW = input_prefetch_fifo_pkg::DW_DEF
) ();
    logic          req;
    logic          ack;
    logic [DW-1:0] data;

    modport master (output req, input ack, input data);
    modport slave  (input req, output ack, output data);
endinterface

// File: rtl/input_prefetch_fifo_sync_fifo.sv
// Small synchronous FIFO with flush; head word is read straight from storage.
module sync_fifo #(
    parameter  int unsigned DW    = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_c,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push_c;
    logic          do_pop_c;
    logic [AW:0]   count_nxt_c;

    // Flush wins over any push or pop in the same cycle.
    assign do_push_c = push && !flush;
    assign do_pop_c  = pop && !flush;
    assign head_c    = mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        if (flush)
            count_nxt_c = '0;
        else if (do_push_c && !do_pop_c)
            count_nxt_c = count + CW'(1);
        else if (!do_push_c && do_pop_c)
            count_nxt_c = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CW'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/input_prefetch_fifo.sv
// Prefetches words from the input unit and serves them to the CU, both over 4-phase req/ack.
module input_prefetch_fifo
    import input_prefetch_fifo_pkg::*;
#(
    parameter  int unsigned DW    = DW_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         prefetch_en,
    input  logic                         flush,
    input_prefetch_fifo_if.master        inp,
    input_prefetch_fifo_if.slave         cu,
    output logic [AW:0]                  count,
    output logic                         full,
    output logic                         empty
);
    up_state_e     u_state;
    dn_state_e     d_state;
    logic          push_c;
    logic          pop_c;
    logic [DW-1:0] head_c;

    assign push_c = (u_state == U_REQ) && inp.ack;
    assign pop_c  = (d_state == D_IDLE) && cu.req && !empty && !flush;

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push_c),
        .push_data (inp.data),
        .pop       (pop_c),
        .flush     (flush),
        .head_c    (head_c),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Upstream: space checked at issue, ack must be low before a new request.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            u_state <= U_IDLE;
            inp.req <= 1'b0;
        end else begin
            case (u_state)
                U_IDLE: if (prefetch_en && !flush && !full && !inp.ack) begin
                    inp.req <= 1'b1;
                    u_state <= U_REQ;
                end
                U_REQ: if (inp.ack) begin
                    inp.req <= 1'b0;
                    u_state <= U_WAIT_LOW;
                end
                U_WAIT_LOW: if (!inp.ack) u_state <= U_IDLE;
                default: begin
                    inp.req <= 1'b0;
                    u_state <= U_IDLE;
                end
            endcase
        end
    end

    // Downstream: grant latches the head word; ack held until the CU drops req.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            d_state <= D_IDLE;
            cu.ack  <= 1'b0;
            cu.data <= '0;
        end else begin
            case (d_state)
                D_IDLE: if (pop_c) begin
                    cu.data <= head_c;
                    cu.ack  <= 1'b1;
                    d_state <= D_ACK;
                end
                D_ACK: if (!cu.req) begin
                    cu.ack  <= 1'b0;
                    d_state <= D_IDLE;
                end
            endcase
        end
    end

endmodule
